key_expansion: RTL and testbench

Sequential AES-128 key schedule for the Cipher datapath. It accepts a 128-bit cipher key over a valid/ready handshake and streams the 11 round keys (round 0..10), one per accepted transfer. Each step computes the next round key from the current one through a single `subWord` instance applied to `rotWord(w3)`, followed by the Rcon XOR and the word XOR chain. Its round-key stream feeds the cipher's AddRoundKey stage.

---
 rtl/key_expansion.sv | 163 ++++++++++++++++
 tb/tb_key_expansion.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// Sequential AES-128 key schedule: accepts a cipher key and streams round keys 0..10
// over a valid/ready handshake, one round key per accepted transfer.
module key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready
);

    typedef enum logic [0:0] {StIdle, StEmit} state_t;

    localparam logic [3:0] LastRound = 4'd10;

    state_t      state;
    logic [31:0] w0, w1, w2, w3;
    logic [3:0]  round;
    logic [7:0]  rcon;

    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        unique case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Single S-box word path: rotWord(w3) through subWord, then the Rcon and XOR chain.
    always_comb begin
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            round <= '0;
            rcon  <= 8'h01;
        end else begin
            unique case (state)
                StIdle: begin
                    if (key_valid) begin
                        w0    <= key_in[127:96];
                        w1    <= key_in[95:64];
                        w2    <= key_in[63:32];
                        w3    <= key_in[31:0];
                        round <= '0;
                        rcon  <= 8'h01;
                        state <= StEmit;
                    end
                end
                StEmit: begin
                    if (rk_ready) begin
                        if (round == LastRound) begin
                            state <= StIdle;
                        end else begin
                            w0    <= n0;
                            w1    <= n1;
                            w2    <= n2;
                            w3    <= n3;
                            round <= round + 4'd1;
                            rcon  <= xtime(rcon);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Outputs come straight from state registers; no input-to-output paths.
    assign key_ready = (state == StIdle);
    assign rk_valid  = (state == StEmit);
    assign rk        = {w0, w1, w2, w3};
    assign rk_idx    = round;

endmodule

// File: tb/tb_key_expansion.sv
// Directed and randomized checks of key_expansion against an independent key-schedule model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_key_expansion;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;

    key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KeyA1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1Idx1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1Idx10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZIdx1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KeyB    = 128'h000102030405060708090a0b0c0d0e0f;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [4];
        logic [31:0] tt;
        logic [7:0]  rc = 8'h01;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        exp_rk[0] = key;
        for (int r = 1; r <= 10; r++) begin
            tt = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
            tt[31:24] = tt[31:24] ^ rc;
            w[0] = w[0] ^ tt;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            exp_rk[r] = {w[0], w[1], w[2], w[3]};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // Presents key at a negedge once key_ready is seen; drops key_valid after the accepting edge.
    task automatic send_key(input logic [127:0] k);
        int n = 0;
        @(negedge clk);
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) check("send_timeout", 128'(key_ready), 128'(1));
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    // Collects 11 transfers. Inputs change and outputs are sampled at negedges.
    task automatic collect(input bit stall, input int inject_at, input logic [127:0] inj_key,
                           output int cycles);
        int           idx = 0;
        bit           prev_stalled = 0;
        bit           injected = 0;
        logic [127:0] prev_rk = '0;
        logic [3:0]   prev_idx = '0;
        cycles = 0;
        while (idx < 11 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (prev_stalled) begin
                check("stall_valid", 128'(rk_valid), 128'(1));
                check("stall_rk", rk, prev_rk);
                check("stall_idx", 128'(rk_idx), 128'(prev_idx));
            end
            if (inject_at >= 0 && !injected && rk_valid && int'(rk_idx) == inject_at) begin
                key_in    = inj_key;
                key_valid = 1'b1;
                injected  = 1;
                check("emit_key_ready", 128'(key_ready), 128'(0));
            end
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
                got_rk[idx] = rk;
                check("rk", rk, exp_rk[idx]);
                check("rk_idx", 128'(rk_idx), 128'(idx));
                idx++;
            end
            prev_stalled = rk_valid && !rk_ready;
            prev_rk      = rk;
            prev_idx     = rk_idx;
        end
        if (idx < 11) check("collect_timeout", 128'(idx), 128'(11));
    endtask

    initial begin
        int cyc;
        int n;
        rst       = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        build_sbox();
        #1;
        check("reset_rk", rk, 128'h0);
        check("reset_idx", 128'(rk_idx), 128'(0));
        check("reset_valid", 128'(rk_valid), 128'(0));
        check("reset_key_ready", 128'(key_ready), 128'(1));
        @(negedge clk);
        rst = 1'b1;

        // A.1 key without stalls: 11 consecutive transfers, then idle.
        model(KeyA1);
        send_key(KeyA1);
        collect(0, -1, '0, cyc);
        check("a1_cycles", 128'(cyc), 128'(11));
        check("a1_idx0", got_rk[0], KeyA1);
        check("a1_idx1", got_rk[1], A1Idx1);
        check("a1_idx10", got_rk[10], A1Idx10);
        @(negedge clk);
        check("a1_key_ready_after", 128'(key_ready), 128'(1));
        check("a1_valid_after", 128'(rk_valid), 128'(0));

        // All-zero key runs rcon through 80 -> 1b -> 36.
        model('0);
        send_key('0);
        collect(0, -1, '0, cyc);
        check("zero_idx1", got_rk[1], ZIdx1);

        // A.1 key with random stalls.
        model(KeyA1);
        send_key(KeyA1);
        collect(1, -1, '0, cyc);

        // A key offered mid-stream is held off until the stream ends.
        model(KeyA1);
        send_key(KeyA1);
        collect(0, 5, KeyB, cyc);
        check("inject_cycles", 128'(cyc), 128'(11));
        model(KeyB);
        send_key(KeyB);
        collect(0, -1, '0, cyc);
        check("held_key_cycles", 128'(cyc), 128'(11));

        // Asynchronous reset at idx 7 abandons the stream.
        model(KeyA1);
        send_key(KeyA1);
        rk_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(rk_valid && rk_idx == 4'd7) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_idx7", 128'(rk_idx), 128'(7));
        #2 rst = 1'b0;
        #1;
        check("mid_reset_valid", 128'(rk_valid), 128'(0));
        check("mid_reset_key_ready", 128'(key_ready), 128'(1));
        check("mid_reset_rk", rk, 128'h0);
        check("mid_reset_idx", 128'(rk_idx), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        send_key(KeyA1);
        collect(0, -1, '0, cyc);
        check("post_reset_idx10", got_rk[10], A1Idx10);

        // Random regression.
        for (int k = 0; k < 1000; k++) begin
            logic [127:0] rkey;
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model(rkey);
            send_key(rkey);
            collect(1, -1, '0, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
